// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings and stage shadow type for the hazard unit
package riscv_pkg;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [4:0] rd;
    logic       reg_write;
    logic [1:0] result_src;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - decode/execute/memory hazard signals between pipeline and hazard unit
interface hazard_ctrl_if;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdD;
  logic        RegWriteD;
  logic [1:0]  ResultSrcD;
  logic        PCSrcE;
  logic        MemReqM;
  logic        MemReadyM;
  logic        StallF;
  logic        StallD;
  logic        StallE;
  logic        StallM;
  logic        FlushD;
  logic        FlushE;
  logic        FlushW;
  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [15:0] LoadUseCnt;
  logic [15:0] FlushCnt;

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    input  ForwardAE, ForwardBE, LoadUseCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
    output ForwardAE, ForwardBE, LoadUseCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - per-operand forward source select, Memory before Writeback
module fwd_sel
  import riscv_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic       reg_write_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_o = FWD_MEM;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward control with shadow E/M/W stage state
module hazard_ctrl
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  stage_t      e_q, e_d, m_q, m_d, w_q, w_d;
  logic [4:0]  rs1e_q, rs1e_d, rs2e_q, rs2e_d;
  logic [15:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;

  logic       mem_wait, load_use;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    mem_wait = hz.MemReqM & ~hz.MemReadyM;
    load_use = (e_q.result_src == RESULT_MEM) && (e_q.rd != 5'd0) &&
               ((e_q.rd == hz.Rs1D) || (e_q.rd == hz.Rs2D));
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        // The whole front of the pipe freezes; pending branch or load-use waits it out.
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = load_use;
        stall_d = load_use;
        flush_d = hz.PCSrcE;
        flush_e = load_use | hz.PCSrcE;
      end
    end
  end

  always_comb begin
    e_d      = e_q;
    rs1e_d   = rs1e_q;
    rs2e_d   = rs2e_q;
    m_d      = m_q;
    w_d      = w_q;
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (mem_wait) begin
      w_d = STAGE_BUBBLE;
    end else begin
      m_d = e_q;
      w_d = m_q;
      if (flush_e) begin
        e_d    = STAGE_BUBBLE;
        rs1e_d = 5'd0;
        rs2e_d = 5'd0;
      end else begin
        e_d.rd         = hz.RdD;
        e_d.reg_write  = hz.RegWriteD;
        e_d.result_src = hz.ResultSrcD;
        rs1e_d         = hz.Rs1D;
        rs2e_d         = hz.Rs2D;
      end
      if (load_use) begin
        lu_cnt_d = sat_inc(lu_cnt_q);
      end
      if (hz.PCSrcE) begin
        fl_cnt_d = sat_inc(fl_cnt_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q      <= STAGE_BUBBLE;
      m_q      <= STAGE_BUBBLE;
      w_q      <= STAGE_BUBBLE;
      rs1e_q   <= 5'd0;
      rs2e_q   <= 5'd0;
      lu_cnt_q <= 16'd0;
      fl_cnt_q <= 16'd0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      rs1e_q   <= rs1e_d;
      rs2e_q   <= rs2e_d;
      lu_cnt_q <= lu_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  fwd_sel u_fwd_a (
    .rs_e_i        (rs1e_q),
    .rd_m_i        (m_q.rd),
    .reg_write_m_i (m_q.reg_write),
    .rd_w_i        (w_q.rd),
    .reg_write_w_i (w_q.reg_write),
    .fwd_o         (fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs_e_i        (rs2e_q),
    .rd_m_i        (m_q.rd),
    .reg_write_m_i (m_q.reg_write),
    .rd_w_i        (w_q.rd),
    .reg_write_w_i (w_q.reg_write),
    .fwd_o         (fwd_b)
  );

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = rst ? FWD_RF : fwd_a;
  assign hz.ForwardBE  = rst ? FWD_RF : fwd_b;
  assign hz.LoadUseCnt = lu_cnt_q;
  assign hz.FlushCnt   = fl_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_ctrl_if hz();

  hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] flg;
  assign flg = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};

  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_LU   = 7'b1100010;
  localparam logic [6:0] F_WAIT = 7'b1111001;
  localparam logic [6:0] F_LUBR = 7'b1100110;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic [1:0] rs);
    hz.Rs1D       = rs1;
    hz.Rs2D       = rs2;
    hz.RdD        = rd;
    hz.RegWriteD  = rw;
    hz.ResultSrcD = rs;
    #1;
  endtask

  task automatic set_ctl(input logic pcsrc, input logic req, input logic rdy);
    hz.PCSrcE    = pcsrc;
    hz.MemReqM   = req;
    hz.MemReadyM = rdy;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_ctl(1'b0, 1'b0, 1'b0);
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    tick();

    // reset state, including a memory wait presented during reset
    set_ctl(1'b0, 1'b1, 1'b0);
    check_eq("rst_flags", 32'(flg), 32'(F_NONE));
    check_eq("rst_fwda", 32'(hz.ForwardAE), 32'd0);
    check_eq("rst_lucnt", 32'(hz.LoadUseCnt), 32'd0);
    check_eq("rst_flcnt", 32'(hz.FlushCnt), 32'd0);
    set_ctl(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;

    // load-use: lw x5 then add x6,x5,x7
    set_d(5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
    check_eq("lw_no_hazard", 32'(flg), 32'(F_NONE));
    tick();
    set_d(5'd5, 5'd7, 5'd6, 1'b1, 2'b00);
    check_eq("lu_flags", 32'(flg), 32'(F_LU));
    check_eq("lu_cnt_pre", 32'(hz.LoadUseCnt), 32'd0);
    tick();
    check_eq("lu_cnt_post", 32'(hz.LoadUseCnt), 32'd1);
    check_eq("lu_once", 32'(flg), 32'(F_NONE));
    check_eq("lu_bubble_fwd", 32'(hz.ForwardAE), 32'd0);
    tick();
    check_eq("lu_fwd_a_wb", 32'(hz.ForwardAE), 32'd1);
    check_eq("lu_fwd_b_rf", 32'(hz.ForwardBE), 32'd0);
    set_d(5'd0, 5'd0, 5'd0, 1'b0, 2'b00);
    tick();

    // double forward: sub x3 in W, add x3 in M
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
    tick();
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
    tick();
    set_d(5'd3, 5'd3, 5'd9, 1'b1, 2'b00);
    tick();
    check_eq("dbl_fwd_a_mem", 32'(hz.ForwardAE), 32'd2);
    check_eq("dbl_fwd_b_mem", 32'(hz.ForwardBE), 32'd2);
    // RdM = x0, RdW = x3
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
    tick();
    set_d(5'd1, 5'd2, 5'd0, 1'b1, 2'b00);
    tick();
    set_d(5'd3, 5'd0, 5'd9, 1'b1, 2'b00);
    tick();
    check_eq("x0m_fwd_a_wb", 32'(hz.ForwardAE), 32'd1);
    check_eq("x0_never_fwd", 32'(hz.ForwardBE), 32'd0);

    // memory wait with held branch and held load-use
    set_d(5'd1, 5'd0, 5'd5, 1'b1, 2'b01);
    check_eq("pre_wait_flags", 32'(flg), 32'(F_NONE));
    tick();
    set_d(5'd5, 5'd7, 5'd6, 1'b1, 2'b00);
    set_ctl(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("wait_flags_%0d", i), 32'(flg), 32'(F_WAIT));
      tick();
    end
    check_eq("wait_flcnt", 32'(hz.FlushCnt), 32'd0);
    check_eq("wait_lucnt", 32'(hz.LoadUseCnt), 32'd1);
    set_ctl(1'b1, 1'b1, 1'b1);
    check_eq("after_wait_flags", 32'(flg), 32'(F_LUBR));
    tick();
    check_eq("after_wait_flcnt", 32'(hz.FlushCnt), 32'd1);
    check_eq("after_wait_lucnt", 32'(hz.LoadUseCnt), 32'd2);
    set_ctl(1'b0, 1'b0, 1'b0);

    // reset in the middle of a memory wait
    set_d(5'd1, 5'd2, 5'd3, 1'b1, 2'b00);
    tick();
    set_d(5'd3, 5'd3, 5'd9, 1'b1, 2'b00);
    tick();
    check_eq("prerst_fwd_a", 32'(hz.ForwardAE), 32'd2);
    set_ctl(1'b0, 1'b1, 1'b0);
    check_eq("prerst_wait", 32'(flg), 32'(F_WAIT));
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_flags", 32'(flg), 32'(F_NONE));
    check_eq("midrst_fwd_a", 32'(hz.ForwardAE), 32'd0);
    tick();
    rst = 1'b0;
    set_ctl(1'b0, 1'b0, 1'b0);
    check_eq("postrst_flags", 32'(flg), 32'(F_NONE));
    check_eq("postrst_lucnt", 32'(hz.LoadUseCnt), 32'd0);
    check_eq("postrst_flcnt", 32'(hz.FlushCnt), 32'd0);
    check_eq("postrst_fwd_a", 32'(hz.ForwardAE), 32'd0);
    tick();
    check_eq("postrst_stale_m", 32'(hz.ForwardAE), 32'd0);

    // saturation: lw x5,0(x5) repeated gives one load-use every two cycles
    set_d(5'd5, 5'd0, 5'd5, 1'b1, 2'b01);
    tick();
    for (int i = 1; i <= 65537; i++) begin
      if (i == 1) check_eq("sat_first_lu", 32'(flg), 32'(F_LU));
      tick();
      if (i == 65534) check_eq("sat_fffe", 32'(hz.LoadUseCnt), 32'hFFFE);
      if (i == 65535) check_eq("sat_ffff", 32'(hz.LoadUseCnt), 32'hFFFF);
      tick();
    end
    check_eq("sat_hold", 32'(hz.LoadUseCnt), 32'hFFFF);
    check_eq("sat_flcnt", 32'(hz.FlushCnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
